// File: rtl/control_sequencer_if.sv
// Control strobe bundle between the hardwired sequencer and the bus-based datapath.
// Latency: none, this is wiring only.
// Backpressure: none; the datapath samples the strobes on every rising edge.
interface control_sequencer_if #(
    parameter int OPW = 5
);
    // IR_view from the datapath. During the IRin state it must already show the
    // word being loaded, because the sequencer decodes the opcode on that same edge.
    logic [31:0]    ir;

    // Bus-out enables
    logic           R_out;
    logic           Zlo_out;
    logic           Zhi_out;
    logic           HI_out;
    logic           LO_out;
    logic           PC_out;
    logic           MDR_out;
    logic           In_out;
    logic           C_out;
    logic           BAout;

    // Register loads and memory/regfile controls
    logic           Rin;
    logic           MARin;
    logic           Zlowin;
    logic           PCin;
    logic           MDRin;
    logic           IRin;
    logic           Yin;
    logic           IncPC;
    logic           Read;
    logic           Write;
    logic           Gra;
    logic           Grb;
    logic           Grc;

    logic [OPW-1:0] op_sel;
    logic           run;
    logic [3:0]     t_step;

    modport master (
        input  ir,
        output R_out, Zlo_out, Zhi_out, HI_out, LO_out, PC_out, MDR_out, In_out, C_out, BAout,
        output Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, Gra, Grb, Grc,
        output op_sel, run, t_step
    );

    modport slave (
        output ir,
        input  R_out, Zlo_out, Zhi_out, HI_out, LO_out, PC_out, MDR_out, In_out, C_out, BAout,
        input  Rin, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, Gra, Grb, Grc,
        input  op_sel, run, t_step
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, decode IR opcode, execute T3-T7, loop or park in HALT.
// Latency: one state per clk; ALU/imm/ldi 6 clks, ld/st 8, nop 3; halt parks after 3.
// Backpressure: none; strobes come only from registered state and the latched opcode.
module control_sequencer #(
    parameter int             OPW    = 5,
    parameter logic [OPW-1:0] OP_ADD = 5'b00011
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);

    // Opcode map
    localparam logic [OPW-1:0] OPC_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OPC_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OPC_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OPC_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OPC_SHL  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OPC_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OPC_ANDI = OPW'(5'b01101);
    localparam logic [OPW-1:0] OPC_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OPC_HALT = OPW'(5'b11011);

    // ALU selects used by the immediate forms
    localparam logic [OPW-1:0] ALU_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] ALU_OR   = OPW'(5'b00110);

    // Encoding doubles as the t_step debug index
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_IMM,
        CL_LDI,
        CL_LD,
        CL_ST,
        CL_HALT
    } cls_t;

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] op_fetch;
    cls_t           cls_fetch;
    cls_t           cls_q;
    logic [OPW-1:0] imm_sel;
    logic           unused_ir;

    // Instruction class from an opcode; anything not listed behaves as nop
    function automatic cls_t classify(input logic [OPW-1:0] op);
        cls_t c;
        case (op)
            OPC_LD:                      c = CL_LD;
            OPC_LDI:                     c = CL_LDI;
            OPC_ST:                      c = CL_ST;
            OPC_ADDI, OPC_ANDI, OPC_ORI: c = CL_IMM;
            OPC_HALT:                    c = CL_HALT;
            default:                     c = (op >= OPC_ADD && op <= OPC_SHL) ? CL_ALU : CL_NOP;
        endcase
        return c;
    endfunction

    assign op_fetch  = bus.ir[31 -: OPW];
    assign unused_ir = ^bus.ir[31-OPW:0];
    assign cls_fetch = classify(op_fetch);
    assign cls_q     = classify(op_q);

    // ALU select for the immediate class; ldi/ld/st reuse OP_ADD for address/immediate sums
    always_comb begin
        imm_sel = OP_ADD;
        if (cls_q == CL_IMM) begin
            if (op_q == OPC_ANDI) begin
                imm_sel = ALU_AND;
            end else if (op_q == OPC_ORI) begin
                imm_sel = ALU_OR;
            end else begin
                imm_sel = OP_ADD;
            end
        end
    end

    // State register; clr aborts whatever is in flight
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode latch at the end of T2, when IR_view carries the fetched word
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q <= '0;
        end else if (state_q == S_T2) begin
            op_q <= op_fetch;
        end
    end

    // Next-state: fetch is common, T2 branches on the incoming opcode, T5 splits memory ops
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2: begin
                case (cls_fetch)
                    CL_HALT: state_d = S_HALT;
                    CL_NOP:  state_d = S_T0;
                    default: state_d = S_T3;
                endcase
            end
            S_T3:  state_d = S_T4;
            S_T4:  state_d = S_T5;
            S_T5:  state_d = (cls_q == CL_LD || cls_q == CL_ST) ? S_T6 : S_T0;
            S_T6:  state_d = S_T7;
            S_T7:  state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Strobe decode from state and latched opcode only; unlisted strobes stay 0
    always_comb begin
        bus.R_out   = 1'b0;
        bus.Zlo_out = 1'b0;
        bus.Zhi_out = 1'b0;
        bus.HI_out  = 1'b0;
        bus.LO_out  = 1'b0;
        bus.PC_out  = 1'b0;
        bus.MDR_out = 1'b0;
        bus.In_out  = 1'b0;
        bus.C_out   = 1'b0;
        bus.BAout   = 1'b0;
        bus.Rin     = 1'b0;
        bus.MARin   = 1'b0;
        bus.Zlowin  = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.op_sel  = '0;
        case (state_q)
            S_T0: begin
                bus.PC_out = 1'b1;
                bus.MARin  = 1'b1;
                bus.Zlowin = 1'b1;
                bus.IncPC  = 1'b1;
            end
            S_T1: begin
                bus.Zlo_out = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDR_out = 1'b1;
                bus.IRin    = 1'b1;
            end
            S_T3: begin
                // Y <= Rb; everything except reg-reg ALU uses the base form (R0 reads as 0)
                bus.Grb   = 1'b1;
                bus.R_out = 1'b1;
                bus.Yin   = 1'b1;
                bus.BAout = (cls_q != CL_ALU);
            end
            S_T4: begin
                bus.Zlowin = 1'b1;
                if (cls_q == CL_ALU) begin
                    bus.Grc    = 1'b1;
                    bus.R_out  = 1'b1;
                    bus.op_sel = op_q;
                end else begin
                    bus.C_out  = 1'b1;
                    bus.op_sel = imm_sel;
                end
            end
            S_T5: begin
                bus.Zlo_out = 1'b1;
                if (cls_q == CL_LD || cls_q == CL_ST) begin
                    bus.MARin = 1'b1;
                end else begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end
            end
            S_T6: begin
                bus.MDRin = 1'b1;
                if (cls_q == CL_LD) begin
                    bus.Read = 1'b1;
                end else begin
                    // Read=0 steers MDR's input mux to the bus for the store data
                    bus.Gra   = 1'b1;
                    bus.R_out = 1'b1;
                end
            end
            S_T7: begin
                if (cls_q == CL_LD) begin
                    bus.MDR_out = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                end else begin
                    bus.Write = 1'b1;
                end
            end
            default: begin
                // RST and HALT drive nothing
            end
        endcase
    end

    // Status outputs
    always_comb begin
        bus.run    = (state_q != S_RST) && (state_q != S_HALT);
        bus.t_step = 4'(state_q);
    end

    // At most one bus driver per state; BAout only ever accompanies R_out
    logic [8:0] bus_drv;
    assign bus_drv = {bus.R_out, bus.Zlo_out, bus.Zhi_out, bus.HI_out, bus.LO_out,
                      bus.PC_out, bus.MDR_out, bus.In_out, bus.C_out};

    a_single_driver: assert property (@(posedge clk) disable iff (!clr) $onehot0(bus_drv));
    a_baout_pair:    assert property (@(posedge clk) disable iff (!clr) bus.BAout |-> bus.R_out);
    a_incpc_t0:      assert property (@(posedge clk) disable iff (!clr) bus.IncPC |-> (state_q == S_T0));
    a_opsel_t4:      assert property (@(posedge clk) disable iff (!clr) (bus.op_sel != '0) |-> (state_q == S_T4));

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: behavioural datapath plus per-instruction strobe and result reference.
// Latency: checks every state of every instruction and the architectural effect after it.
// Backpressure: not applicable.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if #(.OPW(5)) bus ();

    control_sequencer #(.OPW(5), .OP_ADD(5'b00011)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    // Strobe bit positions in the packed observation vector
    localparam logic [22:0] M_ROUT   = 23'd1 << 0;
    localparam logic [22:0] M_RIN    = 23'd1 << 1;
    localparam logic [22:0] M_ZLOOUT = 23'd1 << 2;
    localparam logic [22:0] M_PCOUT  = 23'd1 << 6;
    localparam logic [22:0] M_MDROUT = 23'd1 << 7;
    localparam logic [22:0] M_COUT   = 23'd1 << 9;
    localparam logic [22:0] M_BAOUT  = 23'd1 << 10;
    localparam logic [22:0] M_MARIN  = 23'd1 << 11;
    localparam logic [22:0] M_ZLOWIN = 23'd1 << 12;
    localparam logic [22:0] M_PCIN   = 23'd1 << 13;
    localparam logic [22:0] M_MDRIN  = 23'd1 << 14;
    localparam logic [22:0] M_IRIN   = 23'd1 << 15;
    localparam logic [22:0] M_YIN    = 23'd1 << 16;
    localparam logic [22:0] M_INCPC  = 23'd1 << 17;
    localparam logic [22:0] M_READ   = 23'd1 << 18;
    localparam logic [22:0] M_WRITE  = 23'd1 << 19;
    localparam logic [22:0] M_GRA    = 23'd1 << 20;
    localparam logic [22:0] M_GRB    = 23'd1 << 21;
    localparam logic [22:0] M_GRC    = 23'd1 << 22;

    localparam int K_NOP = 0, K_ALU = 1, K_IMM = 2, K_LDI = 3, K_LD = 4, K_ST = 5, K_HALT = 6;
    localparam logic [31:0] I_HALT = 32'hD800_0000;
    localparam logic [31:0] I_NOP  = 32'hD000_0000;

    logic [22:0] act_s;
    assign act_s = {bus.Grc, bus.Grb, bus.Gra, bus.Write, bus.Read, bus.IncPC, bus.Yin, bus.IRin,
                    bus.MDRin, bus.PCin, bus.Zlowin, bus.MARin, bus.BAout, bus.C_out, bus.In_out,
                    bus.MDR_out, bus.PC_out, bus.LO_out, bus.HI_out, bus.Zhi_out, bus.Zlo_out,
                    bus.Rin, bus.R_out};

    // ---------------- behavioural datapath ----------------
    logic [31:0] rf [16];
    logic [31:0] mem [512];
    logic [31:0] r_init [16];
    logic [31:0] mem_init [512];
    logic [31:0] pc, mar, mdr, irr, y, z, dbus, csx;
    logic        dp_load = 1'b0;
    logic [3:0]  d_ra, d_rb, d_rc, gsel;

    function automatic logic [31:0] alu_f(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (sel)
            5'd3:    return a + b;
            5'd4:    return a - b;
            5'd5:    return a & b;
            5'd6:    return a | b;
            5'd7:    return (a >> s) | (a << (32 - s));
            5'd8:    return (a << s) | (a >> (32 - s));
            5'd9:    return a >> s;
            5'd10:   return 32'($signed(a) >>> s);
            5'd11:   return a << s;
            default: return 32'd0;
        endcase
    endfunction

    assign d_ra = irr[26:23];
    assign d_rb = irr[22:19];
    assign d_rc = irr[18:15];
    assign csx  = {{13{irr[18]}}, irr[18:0]};
    assign gsel = bus.Gra ? d_ra : (bus.Grb ? d_rb : (bus.Grc ? d_rc : 4'd0));
    assign bus.ir = bus.IRin ? dbus : irr;

    always_comb begin
        dbus = 32'd0;
        if (bus.R_out) dbus = (bus.BAout && gsel == 4'd0) ? 32'd0 : rf[gsel];
        else if (bus.Zlo_out) dbus = z;
        else if (bus.PC_out)  dbus = pc;
        else if (bus.MDR_out) dbus = mdr;
        else if (bus.C_out)   dbus = csx;
    end

    always @(posedge clk) begin
        if (dp_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= r_init[i];
            for (int i = 0; i < 512; i++) mem[i] <= mem_init[i];
            pc <= 32'd0; mar <= 32'd0; mdr <= 32'd0; irr <= 32'd0; y <= 32'd0; z <= 32'd0;
        end else begin
            if (bus.Rin)    rf[gsel] <= dbus;
            if (bus.MARin)  mar <= dbus;
            if (bus.Zlowin) z <= bus.IncPC ? dbus + 32'd1 : alu_f(bus.op_sel, y, dbus);
            if (bus.PCin)   pc <= dbus;
            if (bus.IRin)   irr <= dbus;
            if (bus.Yin)    y <= dbus;
            if (bus.MDRin)  mdr <= bus.Read ? mem[mar[8:0]] : dbus;
            if (bus.Write)  mem[mar[8:0]] <= mdr;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] rr [16];
    logic [31:0] rmem [512];
    logic [31:0] rpc;

    function automatic int cls_of(input logic [4:0] op);
        if (op == 5'd0) return K_LD;
        if (op == 5'd1) return K_LDI;
        if (op == 5'd2) return K_ST;
        if (op >= 5'd3 && op <= 5'd11) return K_ALU;
        if (op >= 5'd12 && op <= 5'd14) return K_IMM;
        if (op == 5'd27) return K_HALT;
        return K_NOP;
    endfunction

    function automatic int ilen(input logic [4:0] op);
        int c;
        c = cls_of(op);
        if (c == K_ALU || c == K_IMM || c == K_LDI) return 6;
        if (c == K_LD || c == K_ST) return 8;
        return 3;
    endfunction

    // {op_sel, strobes} required in step k (0 = T0) of an instruction with opcode op
    function automatic logic [27:0] exp_step(input logic [4:0] op, input int k);
        logic [22:0] s;
        logic [4:0]  sel;
        int          c;
        s = '0; sel = '0; c = cls_of(op);
        case (k)
            0: s = M_PCOUT | M_MARIN | M_ZLOWIN | M_INCPC;
            1: s = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN;
            2: s = M_MDROUT | M_IRIN;
            3: s = (c == K_ALU) ? (M_GRB | M_ROUT | M_YIN) : (M_GRB | M_BAOUT | M_ROUT | M_YIN);
            4: begin
                if (c == K_ALU) begin
                    s = M_GRC | M_ROUT | M_ZLOWIN; sel = op;
                end else begin
                    s = M_COUT | M_ZLOWIN;
                    sel = (op == 5'd13) ? 5'd5 : ((op == 5'd14) ? 5'd6 : 5'd3);
                end
            end
            5: s = (c == K_LD || c == K_ST) ? (M_ZLOOUT | M_MARIN) : (M_ZLOOUT | M_GRA | M_RIN);
            6: s = (c == K_LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
            7: s = (c == K_LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
            default: s = '0;
        endcase
        return {sel, s};
    endfunction

    // Architectural effect of one instruction; kind 1 = register idx written, 2 = memory idx written
    task automatic ref_exec(input logic [31:0] iw, output int kind, output int idx);
        logic [4:0]  op;
        logic [3:0]  ra, rb, rc;
        logic [31:0] c, base;
        logic [8:0]  addr;
        op = iw[31:27]; ra = iw[26:23]; rb = iw[22:19]; rc = iw[18:15];
        c = {{13{iw[18]}}, iw[18:0]};
        base = (rb == 4'd0) ? 32'd0 : rr[rb];
        addr = 9'(base + c);
        kind = 0; idx = 0;
        rpc = rpc + 32'd1;
        case (cls_of(op))
            K_LD:  begin rr[ra] = rmem[addr]; kind = 1; idx = int'(ra); end
            K_LDI: begin rr[ra] = base + c; kind = 1; idx = int'(ra); end
            K_ST:  begin rmem[addr] = rr[ra]; kind = 2; idx = int'(addr); end
            K_ALU: begin rr[ra] = alu_f(op, rr[rb], rr[rc]); kind = 1; idx = int'(ra); end
            K_IMM: begin
                rr[ra] = (op == 5'd12) ? base + c : ((op == 5'd13) ? (base & c) : (base | c));
                kind = 1; idx = int'(ra);
            end
            default: kind = 0;
        endcase
    endtask

    task automatic clear_inits();
        for (int i = 0; i < 16; i++) r_init[i] = 32'd0;
        for (int i = 0; i < 512; i++) mem_init[i] = 32'd0;
    endtask

    // Reset DUT, load datapath and reference, release clr on a falling edge
    task automatic boot();
        clr = 1'b0;
        dp_load = 1'b1;
        for (int i = 0; i < 16; i++) rr[i] = r_init[i];
        for (int i = 0; i < 512; i++) rmem[i] = mem_init[i];
        rpc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dp_load = 1'b0;
        clr = 1'b1;
    endtask

    // Step through n instructions from the reference PC, checking each state and each result
    task automatic run_prog(input int n_instr, input int park);
        logic [31:0] iw;
        logic [4:0]  op;
        logic [27:0] e;
        int kind, idx;
        for (int n = 0; n < n_instr; n++) begin
            iw = rmem[rpc[8:0]];
            op = iw[31:27];
            for (int k = 0; k < ilen(op); k++) begin
                @(negedge clk);
                e = exp_step(op, k);
                n_chk++;
                if ({bus.op_sel, act_s} !== e) begin
                    n_err++;
                    $display("FAIL strobes op=%0d step%0d: got %h want %h", op, k, {bus.op_sel, act_s}, e);
                end
                n_chk++;
                if (bus.t_step !== 4'(k + 1) || bus.run !== 1'b1) begin
                    n_err++;
                    $display("FAIL t_step/run op=%0d step%0d: got %0d/%b want %0d/1", op, k, bus.t_step, bus.run, k + 1);
                end
            end
            if (cls_of(op) == K_HALT) begin
                for (int p = 0; p < park; p++) begin
                    @(negedge clk);
                    n_chk++;
                    if ({bus.op_sel, act_s, bus.run, bus.t_step} !== {5'd0, 23'd0, 1'b0, 4'd15}) begin
                        n_err++;
                        $display("FAIL halt_park cyc%0d: got strobes %h run %b t_step %0d want 0/0/15", p, act_s, bus.run, bus.t_step);
                    end
                end
                return;
            end
            ref_exec(iw, kind, idx);
            @(posedge clk);
            #1;
            n_chk++;
            if (pc !== rpc) begin
                n_err++;
                $display("FAIL pc after op=%0d: got %h want %h", op, pc, rpc);
            end
            if (kind == 1) begin
                n_chk++;
                if (rf[idx] !== rr[idx]) begin
                    n_err++;
                    $display("FAIL reg R%0d after op=%0d: got %h want %h", idx, op, rf[idx], rr[idx]);
                end
            end else if (kind == 2) begin
                n_chk++;
                if (mem[idx] !== rmem[idx]) begin
                    n_err++;
                    $display("FAIL mem[%h] after st: got %h want %h", idx, mem[idx], rmem[idx]);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inits();
        mem_init[0] = I_HALT;
        clr = 1'b0;
        dp_load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus.op_sel, act_s, bus.run, bus.t_step} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {bus.op_sel, act_s, bus.run, bus.t_step});
        end
        dp_load = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.t_step !== 4'd1 || bus.run !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got t_step %0d run %b want 1/1", bus.t_step, bus.run);
        end
    endtask

    task automatic test_clr_abort();
        int t;
        clear_inits();
        r_init[2] = 32'hDEAD_0002; r_init[5] = 32'h45; r_init[6] = 32'h50;
        mem_init[0] = 32'h1932_8000;
        boot();
        t = 0;
        while (bus.t_step !== 4'd5 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (bus.t_step !== 4'd5) begin
            n_err++;
            $display("FAIL abort_reach_t4: got t_step %0d want 5", bus.t_step);
        end
        #2 clr = 1'b0;
        #1;
        n_chk++;
        if ({bus.op_sel, act_s, bus.run, bus.t_step} !== 33'd0) begin
            n_err++;
            $display("FAIL abort_immediate: got %h want 0", {bus.op_sel, act_s, bus.run, bus.t_step});
        end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (rf[2] !== 32'hDEAD_0002) begin
            n_err++;
            $display("FAIL abort_no_rin: got R2 %h want dead0002", rf[2]);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.t_step !== 4'd1 || bus.run !== 1'b1) begin
            n_err++;
            $display("FAIL abort_restart: got t_step %0d run %b want 1/1", bus.t_step, bus.run);
        end
    endtask

    task automatic test_andi();
        clear_inits();
        r_init[5] = 32'h45; r_init[6] = 32'h50;
        mem_init[0] = 32'h6AB0_0095; mem_init[1] = I_HALT;
        boot();
        run_prog(2, 3);
        n_chk++;
        if (rf[5] !== 32'h10) begin
            n_err++;
            $display("FAIL andi_result: got R5 %h want 00000010", rf[5]);
        end
    endtask

    task automatic test_add();
        clear_inits();
        r_init[5] = 32'h45; r_init[6] = 32'h50;
        mem_init[0] = 32'h1932_8000; mem_init[1] = I_HALT;
        boot();
        run_prog(2, 3);
        n_chk++;
        if (rf[2] !== 32'h95) begin
            n_err++;
            $display("FAIL add_result: got R2 %h want 00000095", rf[2]);
        end
    endtask

    task automatic test_ld();
        logic [31:0] v;
        v = $urandom;
        clear_inits();
        mem_init[9'h54] = v;
        mem_init[0] = 32'h0080_0054; mem_init[1] = I_HALT;
        boot();
        run_prog(2, 3);
        n_chk++;
        if (rf[1] !== v) begin
            n_err++;
            $display("FAIL ld_result: got R1 %h want %h", rf[1], v);
        end
    endtask

    task automatic test_st();
        logic [31:0] v;
        v = $urandom;
        clear_inits();
        r_init[3] = 32'h10; r_init[4] = v;
        mem_init[0] = 32'h1218_0087; mem_init[1] = I_HALT;
        boot();
        run_prog(2, 3);
        n_chk++;
        if (mem[9'h97] !== v) begin
            n_err++;
            $display("FAIL st_result: got mem[97] %h want %h", mem[9'h97], v);
        end
    endtask

    task automatic test_nop_halt();
        clear_inits();
        mem_init[0] = I_NOP; mem_init[1] = I_HALT;
        boot();
        run_prog(2, 20);
    endtask

    task automatic test_random_stream();
        logic [4:0]  op;
        logic [3:0]  ra, rb;
        logic [18:0] c;
        int pick;
        for (int round = 0; round < 4; round++) begin
            clear_inits();
            for (int i = 0; i < 16; i++) r_init[i] = $urandom;
            for (int i = 256; i < 512; i++) mem_init[i] = $urandom;
            for (int n = 0; n < 15; n++) begin
                pick = $urandom_range(0, 9);
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                c  = 19'($urandom);
                case (pick)
                    0, 2: begin
                        op = (pick == 0) ? 5'd0 : 5'd2;
                        rb = 4'd0;
                        c  = 19'(32'h100 + $urandom_range(0, 255));
                    end
                    1:       op = 5'd1;
                    6:       op = 5'($urandom_range(12, 14));
                    7:       op = 5'd26;
                    8:       op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(15, 25)) : 5'($urandom_range(28, 31));
                    default: op = 5'($urandom_range(3, 11));
                endcase
                mem_init[n] = {op, ra, rb, c};
            end
            mem_init[15] = I_HALT;
            boot();
            run_prog(16, 2);
        end
    endtask

    initial begin
        test_reset();
        test_clr_abort();
        test_andi();
        test_add();
        test_ld();
        test_st();
        test_nop_halt();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
